// File: rtl/cluster_pkg.sv
// Shared widths, FSM encoding and constants for the cluster extraction sequencer.
package cluster_pkg;
    localparam int MXKEYS      = 192;
    localparam int MXKEYBITS   = 8;
    localparam int MXCNTB      = 3;
    localparam int MXCLUSTERS  = 8;
    localparam int ENC_LATENCY = 2;
    localparam int PASSB       = 3;

    localparam logic [MXKEYBITS-1:0] EMPTY_ADR = '1;
    localparam logic [PASSB-1:0]     PASS_IDLE = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/cluster_slot_store.sv
// Per-slot address/count registers and the valid mask for one frame's cluster list.
module cluster_slot_store
    import cluster_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             i_clr,
    input  logic                             i_wr,
    input  logic [PASSB-1:0]                 i_wr_idx,
    input  logic [MXKEYBITS-1:0]             i_wr_adr,
    input  logic [MXCNTB-1:0]                i_wr_cnt,
    output logic [MXCLUSTERS*MXKEYBITS-1:0]  o_adr,
    output logic [MXCLUSTERS*MXCNTB-1:0]     o_cnt,
    output logic [MXCLUSTERS-1:0]            o_vld
);
    logic [MXKEYBITS-1:0] r_adr [MXCLUSTERS];
    logic [MXCNTB-1:0]    r_cnt [MXCLUSTERS];
    logic [MXCLUSTERS-1:0] r_vld;

    genvar gi;
    generate
        for (gi = 0; gi < MXCLUSTERS; gi++) begin : g_slot
            always_ff @(posedge clock) begin
                if (reset || i_clr) begin
                    r_adr[gi] <= '0;
                    r_cnt[gi] <= '0;
                    r_vld[gi] <= 1'b0;
                end else if (i_wr && (i_wr_idx == PASSB'(gi))) begin
                    r_adr[gi] <= i_wr_adr;
                    r_cnt[gi] <= i_wr_cnt;
                    r_vld[gi] <= 1'b1;
                end
            end
            assign o_adr[gi*MXKEYBITS +: MXKEYBITS] = r_adr[gi];
            assign o_cnt[gi*MXCNTB +: MXCNTB]       = r_cnt[gi];
        end
    endgenerate

    assign o_vld = r_vld;
endmodule

// File: rtl/cluster_extract_ctrl.sv
// Iterative cluster extractor: drives an external priority encoder with a working pad
// vector, records each winner into a slot and clears it until empty or the list is full.
module cluster_extract_ctrl
    import cluster_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             frame_valid_i,
    input  logic [MXKEYS-1:0]                vpfs_i,
    input  logic [MXKEYS*MXCNTB-1:0]         cnts_i,
    output logic [MXKEYS-1:0]                enc_vpfs_o,
    output logic [MXKEYS*MXCNTB-1:0]         enc_cnts_o,
    output logic [PASSB-1:0]                 enc_pass_o,
    input  logic [MXKEYBITS-1:0]             enc_adr_i,
    input  logic                             enc_vpf_i,
    input  logic [MXCNTB-1:0]                enc_cnt_i,
    input  logic [PASSB-1:0]                 enc_pass_i,
    output logic [MXCLUSTERS*MXKEYBITS-1:0]  cluster_adr_o,
    output logic [MXCLUSTERS*MXCNTB-1:0]     cluster_cnt_o,
    output logic [MXCLUSTERS-1:0]            cluster_vld_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             overflow_o,
    output logic                             frame_drop_o,
    output logic                             sync_err_o
);
    state_t                    r_state, w_state_next;
    logic [MXKEYS-1:0]         r_work;
    logic [MXKEYS*MXCNTB-1:0]  r_cnts;
    logic [PASSB-1:0]          r_idx;
    logic [1:0]                r_wait;
    logic                      r_ovf;
    logic                      r_serr;

    logic                      w_accept;
    logic                      w_eval;
    logic                      w_bad;
    logic                      w_hit;
    logic                      w_last;
    logic [MXKEYS-1:0]         w_work_after;

    assign w_accept     = (r_state == ST_IDLE) && frame_valid_i;
    assign w_eval       = (r_state == ST_WAIT) && (r_wait == 2'(ENC_LATENCY-1));
    // A stale tag or an impossible address means the encoder result cannot be trusted.
    assign w_bad        = (enc_pass_i != r_idx) ||
                          (enc_vpf_i && (enc_adr_i >= MXKEYBITS'(MXKEYS)));
    assign w_hit        = w_eval && !w_bad && enc_vpf_i;
    assign w_last       = (r_idx == PASSB'(MXCLUSTERS-1));
    assign w_work_after = r_work & ~(MXKEYS'(1) << enc_adr_i);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (frame_valid_i) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_eval) begin
                    if (w_bad || !enc_vpf_i || w_last) w_state_next = ST_DONE;
                    else                              w_state_next = ST_ISSUE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_cnts  <= '0;
            r_idx   <= '0;
            r_wait  <= '0;
            r_ovf   <= 1'b0;
            r_serr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_work <= vpfs_i;
                r_cnts <= cnts_i;
                r_idx  <= '0;
                r_ovf  <= 1'b0;
                r_serr <= 1'b0;
            end
            if (r_state == ST_ISSUE)     r_wait <= '0;
            else if (r_state == ST_WAIT) r_wait <= r_wait + 2'd1;
            if (w_eval && w_bad) r_serr <= 1'b1;
            if (w_hit) begin
                r_work <= w_work_after;
                r_idx  <= r_idx + PASSB'(1);
                if (w_last) r_ovf <= |w_work_after;
            end
        end
    end

    cluster_slot_store u_slots (
        .clock    (clock),
        .reset    (reset),
        .i_clr    (w_accept),
        .i_wr     (w_hit),
        .i_wr_idx (r_idx),
        .i_wr_adr (enc_adr_i),
        .i_wr_cnt (enc_cnt_i),
        .o_adr    (cluster_adr_o),
        .o_cnt    (cluster_cnt_o),
        .o_vld    (cluster_vld_o)
    );

    assign enc_vpfs_o   = r_work;
    assign enc_cnts_o   = r_cnts;
    assign enc_pass_o   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) ? PASS_IDLE : r_idx;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign overflow_o   = r_ovf;
    assign sync_err_o   = r_serr;
    assign frame_drop_o = frame_valid_i && (r_state != ST_IDLE) && !reset;
endmodule

// File: tb/tb_cluster_extract_ctrl.sv
// Bench for cluster_extract_ctrl: behavioural 2-cycle priority encoder, table of frames,
// scoreboard queue of expected results, plus drop / tag-mismatch / mid-frame reset sequences.
module tb_cluster_extract_ctrl;
    import cluster_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                             reset;
    logic                             frame_valid_i;
    logic [MXKEYS-1:0]                vpfs_i;
    logic [MXKEYS*MXCNTB-1:0]         cnts_i;
    logic [MXKEYS-1:0]                enc_vpfs_o;
    logic [MXKEYS*MXCNTB-1:0]         enc_cnts_o;
    logic [PASSB-1:0]                 enc_pass_o;
    logic [MXKEYBITS-1:0]             enc_adr_i;
    logic                             enc_vpf_i;
    logic [MXCNTB-1:0]                enc_cnt_i;
    logic [PASSB-1:0]                 enc_pass_i;
    logic [MXCLUSTERS*MXKEYBITS-1:0]  cluster_adr_o;
    logic [MXCLUSTERS*MXCNTB-1:0]     cluster_cnt_o;
    logic [MXCLUSTERS-1:0]            cluster_vld_o;
    logic                             busy_o, done_o, overflow_o, frame_drop_o, sync_err_o;

    cluster_extract_ctrl dut (
        .clock(clock), .reset(reset), .frame_valid_i(frame_valid_i),
        .vpfs_i(vpfs_i), .cnts_i(cnts_i),
        .enc_vpfs_o(enc_vpfs_o), .enc_cnts_o(enc_cnts_o), .enc_pass_o(enc_pass_o),
        .enc_adr_i(enc_adr_i), .enc_vpf_i(enc_vpf_i), .enc_cnt_i(enc_cnt_i),
        .enc_pass_i(enc_pass_i),
        .cluster_adr_o(cluster_adr_o), .cluster_cnt_o(cluster_cnt_o),
        .cluster_vld_o(cluster_vld_o), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o), .frame_drop_o(frame_drop_o), .sync_err_o(sync_err_o)
    );

    // Encoder model: lowest set pad wins, result appears two clocks after the input.
    logic                 m_vpf;
    logic [MXKEYBITS-1:0] m_adr;
    logic [MXCNTB-1:0]    m_cnt;
    always_comb begin
        m_vpf = 1'b0;
        m_adr = EMPTY_ADR;
        m_cnt = '0;
        for (int n = MXKEYS - 1; n >= 0; n--) begin
            if (enc_vpfs_o[n]) begin
                m_vpf = 1'b1;
                m_adr = MXKEYBITS'(n);
                m_cnt = enc_cnts_o[n*MXCNTB +: MXCNTB];
            end
        end
    end

    logic                 p1_vpf = 1'b0, p2_vpf = 1'b0;
    logic [MXKEYBITS-1:0] p1_adr = '1, p2_adr = '1;
    logic [MXCNTB-1:0]    p1_cnt = '0, p2_cnt = '0;
    logic [PASSB-1:0]     p1_pass = '1, p2_pass = '1;
    logic                 force_tag = 1'b0;
    always @(posedge clock) begin
        p1_vpf <= m_vpf;  p1_adr <= m_adr;  p1_cnt <= m_cnt;  p1_pass <= enc_pass_o;
        p2_vpf <= p1_vpf; p2_adr <= p1_adr; p2_cnt <= p1_cnt; p2_pass <= p1_pass;
    end
    assign enc_vpf_i  = p2_vpf;
    assign enc_adr_i  = p2_adr;
    assign enc_cnt_i  = p2_cnt;
    assign enc_pass_i = force_tag ? 3'd3 : p2_pass;

    typedef struct {
        logic [MXKEYS-1:0]        v;
        logic [MXKEYS*MXCNTB-1:0] c;
        logic [7:0]               evld;
        logic                     eovf;
        int                       edone;
    } vec_t;

    typedef struct {
        logic [7:0]  vld;
        logic [63:0] adr;
        logic [23:0] cnt;
        logic        ovf;
        logic        serr;
        int          done;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_frame = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic exp_t ref_model(input logic [MXKEYS-1:0] v, input logic [MXKEYS*MXCNTB-1:0] c,
                                       input logic [7:0] evld, input logic eovf, input logic eserr,
                                       input int edone);
        exp_t e;
        int   k;
        k     = 0;
        e.adr = '0;
        e.cnt = '0;
        for (int n = 0; n < MXKEYS; n++) begin
            if (v[n] && k < MXCLUSTERS) begin
                e.adr[k*8 +: 8] = 8'(n);
                e.cnt[k*3 +: 3] = c[n*3 +: 3];
                k++;
            end
        end
        e.vld  = evld;
        e.ovf  = eovf;
        e.serr = eserr;
        e.done = edone;
        return e;
    endfunction

    task automatic run_frame(input logic [MXKEYS-1:0] v, input logic [MXKEYS*MXCNTB-1:0] c,
                             input exp_t e, input int drop_at);
        int   cyc;
        bit   got;
        exp_t x;
        @(negedge clock);
        frame_valid_i = 1'b1; vpfs_i = v; cnts_i = c;
        sb_q.push_back(e);
        @(negedge clock);
        frame_valid_i = 1'b0; vpfs_i = '0;
        cyc = 1; got = 1'b0;
        while (cyc <= 60) begin
            if (cyc == drop_at) begin
                frame_valid_i = 1'b1; vpfs_i = '1;
                #1;
                check("frame_drop", 64'(frame_drop_o), 64'd1);
            end
            if (done_o) begin got = 1'b1; break; end
            @(negedge clock);
            frame_valid_i = 1'b0; vpfs_i = '0;
            cyc++;
        end
        x = sb_q.pop_front();
        if (!got) begin
            n_total++;
            $display("FAIL done_timeout: got no done_o within 60 cycles, expected cycle %0d", x.done);
        end else begin
            check("done_cycle", 64'(cyc), 64'(x.done));
            check("cluster_vld", 64'(cluster_vld_o), 64'(x.vld));
            check("overflow", 64'(overflow_o), 64'(x.ovf));
            check("sync_err", 64'(sync_err_o), 64'(x.serr));
            for (int i = 0; i < MXCLUSTERS; i++) begin
                if (x.vld[i]) begin
                    check($sformatf("slot%0d_adr", i), 64'(cluster_adr_o[i*8 +: 8]), 64'(x.adr[i*8 +: 8]));
                    check($sformatf("slot%0d_cnt", i), 64'(cluster_cnt_o[i*3 +: 3]), 64'(x.cnt[i*3 +: 3]));
                end
            end
        end
        $display("frame %0d: done@%0d vld=%h ovf=%b serr=%b", n_frame, cyc, cluster_vld_o,
                 overflow_o, sync_err_o);
        n_frame++;
        @(posedge clock);
        #1;
        frame_valid_i = 1'b0; vpfs_i = '0;
        @(negedge clock);
        check("busy_after_done", 64'(busy_o), 64'd0);
        check("done_one_cycle", 64'(done_o), 64'd0);
    endtask

    vec_t vecs[6];

    function automatic logic [MXKEYS*MXCNTB-1:0] rand_cnts();
        logic [MXKEYS*MXCNTB-1:0] c;
        for (int n = 0; n < MXKEYS; n++) c[n*3 +: 3] = 3'($urandom_range(7));
        return c;
    endfunction

    initial begin
        logic [MXKEYS-1:0]        v;
        logic [MXKEYS*MXCNTB-1:0] c;

        v = '0; c = '0;
        vecs[0] = '{v, rand_cnts(), 8'h00, 1'b0, 4};
        v[5] = 1'b1; v[17] = 1'b1; v[190] = 1'b1;
        c[5*3 +: 3] = 3'd1; c[17*3 +: 3] = 3'd3; c[190*3 +: 3] = 3'd7;
        vecs[1] = '{v, c, 8'h07, 1'b0, 13};
        v = '0; for (int n = 0; n < 12; n++) v[n] = 1'b1;
        vecs[2] = '{v, rand_cnts(), 8'hFF, 1'b1, 25};
        v = '0; v[3] = 1; v[20] = 1; v[50] = 1; v[64] = 1; v[100] = 1; v[128] = 1; v[150] = 1; v[191] = 1;
        vecs[3] = '{v, rand_cnts(), 8'hFF, 1'b0, 25};
        v = '0; v[191] = 1'b1;
        vecs[4] = '{v, rand_cnts(), 8'h01, 1'b0, 7};
        v = '0; v[0] = 1'b1; v[191] = 1'b1;
        vecs[5] = '{v, rand_cnts(), 8'h03, 1'b0, 10};

        reset = 1'b1; frame_valid_i = 1'b0; vpfs_i = '0; cnts_i = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_vld", 64'(cluster_vld_o), 64'd0);
        check("rst_pass", 64'(enc_pass_o), 64'd7);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_serr", 64'(sync_err_o), 64'd0);
        check("rst_work", 64'(|enc_vpfs_o), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].v, vecs[i].c,
                      ref_model(vecs[i].v, vecs[i].c, vecs[i].evld, vecs[i].eovf, 1'b0, vecs[i].edone), -1);
            if (i == 1) begin
                check("tri_adr", 64'(cluster_adr_o[23:0]), 64'h00BE1105);
                check("tri_cnt", 64'(cluster_cnt_o[8:0]), 64'(9'b111_011_001));
            end
        end

        // Mid-frame drop: the intruding frame must not disturb the active one.
        run_frame(vecs[1].v, vecs[1].c, ref_model(vecs[1].v, vecs[1].c, 8'h07, 1'b0, 1'b0, 13), 5);
        // A frame arriving with done_o is dropped as well.
        run_frame(vecs[0].v, vecs[0].c, ref_model(vecs[0].v, vecs[0].c, 8'h00, 1'b0, 1'b0, 4), 4);

        // Returned pass tag mismatch on pass 0.
        force_tag = 1'b1;
        run_frame(vecs[4].v, vecs[4].c, ref_model(vecs[4].v, vecs[4].c, 8'h00, 1'b0, 1'b1, 4), -1);
        force_tag = 1'b0;
        repeat (3) @(negedge clock);

        // Reset during a WAIT cycle of a busy frame.
        @(negedge clock);
        frame_valid_i = 1'b1; vpfs_i = vecs[2].v; cnts_i = vecs[2].c;
        @(negedge clock);
        frame_valid_i = 1'b0; vpfs_i = '0;
        repeat (4) @(negedge clock);
        check("pre_rst_vld", 64'(cluster_vld_o), 64'h01);
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_vld", 64'(cluster_vld_o), 64'd0);
        check("midrst_pass", 64'(enc_pass_o), 64'd7);
        check("midrst_work", 64'(|enc_vpfs_o), 64'd0);
        check("midrst_adr", 64'(|cluster_adr_o), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("post_rst_done", 64'(done_o), 64'd0);
        run_frame(vecs[5].v, vecs[5].c, ref_model(vecs[5].v, vecs[5].c, 8'h03, 1'b0, 1'b0, 10), -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
